// File: rtl/hermes_tx_if.sv
// Flit stream bundle: source-side valid/ready handshake plus the
// Hermes-side tx/credit link. The transmitter uses the slave view.
interface hermes_tx_if #(
   parameter int HERMES_FLIT_SIZE = 32
);
   logic                        src_valid_i;
   logic                        src_ready_o;
   logic [HERMES_FLIT_SIZE-1:0] src_data_i;
   logic                        noc_tx_o;
   logic                        noc_credit_i;
   logic [HERMES_FLIT_SIZE-1:0] noc_data_o;

   // Transmitter side
   modport slave (
      input  src_valid_i,
      input  src_data_i,
      input  noc_credit_i,
      output src_ready_o,
      output noc_tx_o,
      output noc_data_o
   );

   // Source / receiver side (bench or surrounding logic)
   modport master (
      output src_valid_i,
      output src_data_i,
      output noc_credit_i,
      input  src_ready_o,
      input  noc_tx_o,
      input  noc_data_o
   );
endinterface

// File: rtl/hermes_tx.sv
// Hermes NoC transmitter: first-word-fall-through staging FIFO feeding a
// credit-based link, with a packet tracker (header, size, payload) that
// pulses pkt_sent_o and counts packets once the last flit has left.
module hermes_tx #(
   parameter int HERMES_FLIT_SIZE = 32,
   parameter int BUFFER_SIZE      = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   hermes_tx_if.slave   bus,
   output logic         busy_o,
   output logic         pkt_sent_o,
   output logic [31:0]  sent_count_o
);
   localparam int AW = $clog2(BUFFER_SIZE);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {HEADER, SIZE, PAYLOAD} state_t;

   logic [HERMES_FLIT_SIZE-1:0] mem [BUFFER_SIZE];

   logic [AW:0] wr_ptr_reg, wr_ptr_next;
   logic [AW:0] rd_ptr_reg, rd_ptr_next;
   state_t      state_reg, state_next;
   logic [31:0] remaining_reg, remaining_next;
   logic [31:0] sent_count_reg;
   logic        pkt_sent_reg;
   logic        busy_reg, busy_next;
   logic        pkt_done;
   logic        full, empty, push, pop;
   logic [31:0] size_val;

   // Extra pointer bit tells full (same index, different lap) from empty.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // No write-through when full, no bypass when empty.
   assign push = bus.src_valid_i && !full;
   assign pop  = bus.noc_credit_i && !empty;

   assign bus.src_ready_o = !full;
   assign bus.noc_tx_o    = !empty;
   assign bus.noc_data_o  = mem[rd_ptr_reg[AW-1:0]];

   assign wr_ptr_next = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
   assign rd_ptr_next = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

   // Size flit is read as a 32-bit length: truncate wide flits, zero-extend narrow ones.
   generate
      if (HERMES_FLIT_SIZE >= 32) begin : g_size_trunc
         assign size_val = bus.noc_data_o[31:0];
      end else begin : g_size_zext
         assign size_val = {{(32-HERMES_FLIT_SIZE){1'b0}}, bus.noc_data_o};
      end
   endgenerate

   // FIFO storage write; contents are don't-care after reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= bus.src_data_i;
      end
   end

   // Packet tracker next state: advances only on link transfers.
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      pkt_done       = 1'b0;
      case (state_reg)
         HEADER: begin
            if (pop) begin
               state_next = SIZE;
            end
         end
         SIZE: begin
            if (pop) begin
               remaining_next = size_val;
               if (size_val == 32'd0) begin
                  state_next = HEADER;
                  pkt_done   = 1'b1;
               end else begin
                  state_next = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (pop) begin
               remaining_next = remaining_reg - 32'd1;
               if (remaining_reg == 32'd1) begin
                  state_next = HEADER;
                  pkt_done   = 1'b1;
               end
            end
         end
         default: state_next = HEADER;
      endcase
      busy_next = (state_next != HEADER) || (wr_ptr_next != rd_ptr_next);
   end

   // Pointers, tracker state and registered status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         state_reg      <= HEADER;
         remaining_reg  <= '0;
         pkt_sent_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         sent_count_reg <= '0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         pkt_sent_reg  <= pkt_done;
         busy_reg      <= busy_next;
         if (pkt_done) begin
            sent_count_reg <= sent_count_reg + 32'd1;
         end
      end
   end

   assign pkt_sent_o   = pkt_sent_reg;
   assign busy_o       = busy_reg;
   assign sent_count_o = sent_count_reg;
endmodule

// File: tb/tb_hermes_tx.sv
// Randomized bench for hermes_tx: a queue-based reference model predicts
// FIFO occupancy, head flit, packet boundaries (from header+size+payload
// lengths) and the packet counter; every cycle the DUT is compared to it.
module tb_hermes_tx;
   localparam int W   = 32;
   localparam int BUF = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        busy_o;
   logic        pkt_sent_o;
   logic [31:0] sent_count_o;

   hermes_tx_if #(.HERMES_FLIT_SIZE(W)) bus ();

   hermes_tx #(.HERMES_FLIT_SIZE(W), .BUFFER_SIZE(BUF)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus),
      .busy_o       (busy_o),
      .pkt_sent_o   (pkt_sent_o),
      .sent_count_o (sent_count_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] mq[$];      // flits accepted but not yet transferred
   logic [31:0] src_q[$];   // flits the source still has to offer
   longint      pkt_pos   = 0;   // flits of current packet already sent
   longint      pkt_total = 0;   // header + size + payload
   logic [31:0] exp_count = '0;
   bit          exp_pulse = 1'b0;
   bit          exp_busy  = 1'b0;
   int          n_xfer    = 0;
   int          n_pkts    = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("src_ready", 64'(bus.src_ready_o), 64'(mq.size() < BUF));
      check_val("noc_tx", 64'(bus.noc_tx_o), 64'(mq.size() != 0));
      if (mq.size() != 0) check_val("noc_data", 64'(bus.noc_data_o), 64'(mq[0]));
      check_val("pkt_sent", 64'(pkt_sent_o), 64'(exp_pulse));
      check_val("sent_count", 64'(sent_count_o), 64'(exp_count));
      check_val("busy", 64'(busy_o), 64'(exp_busy));
   endtask

   // Predict what the coming rising edge does with the chosen inputs.
   task automatic model_update(input bit v, input logic [31:0] d, input bit c, output bit pushed);
      bit do_pop, done;
      logic [31:0] f;
      do_pop = c && (mq.size() != 0);
      pushed = v && (mq.size() < BUF);
      done   = 1'b0;
      if (do_pop) begin
         f = mq.pop_front();
         n_xfer++;
         if (pkt_pos == 1) pkt_total = longint'(f) + 2;
         pkt_pos++;
         if (pkt_pos >= 2 && pkt_pos == pkt_total) begin
            done    = 1'b1;
            pkt_pos = 0;
         end
      end
      if (pushed) mq.push_back(d);
      exp_pulse = done;
      if (done) begin
         exp_count = exp_count + 32'd1;
         n_pkts++;
         $display("packet %0d complete, expected count=%0d", n_pkts, exp_count);
      end
      exp_busy = (pkt_pos != 0) || (mq.size() != 0);
   endtask

   task automatic step(input bit v, input logic [31:0] d, input bit c, output bit pushed);
      @(negedge clk_i);
      check_outputs();
      bus.src_valid_i  = v;
      bus.src_data_i   = d;
      bus.noc_credit_i = c;
      #1;
      model_update(v, d, c, pushed);
   endtask

   // Offer src_q with the given valid/credit percentages until drained.
   task automatic run_src(input int vp, input int cp, input int max_cycles);
      int  cyc;
      bit  v, c, pushed;
      cyc = 0;
      while ((src_q.size() != 0 || mq.size() != 0) && cyc < max_cycles) begin
         v = (src_q.size() != 0) && ($urandom_range(99) < vp);
         c = ($urandom_range(99) < cp);
         step(v, v ? src_q[0] : 32'h0, c, pushed);
         if (pushed) void'(src_q.pop_front());
         cyc++;
      end
      check_val("drain_in_bound", 64'(cyc < max_cycles), 64'd1);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, pushed);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      bus.src_valid_i  = 1'b0;
      bus.noc_credit_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      check_val("rst_noc_tx", 64'(bus.noc_tx_o), 64'd0);
      check_val("rst_src_ready", 64'(bus.src_ready_o), 64'd1);
      check_val("rst_busy", 64'(busy_o), 64'd0);
      check_val("rst_pkt_sent", 64'(pkt_sent_o), 64'd0);
      check_val("rst_sent_count", 64'(sent_count_o), 64'd0);
      mq.delete();
      pkt_pos   = 0;
      exp_pulse = 1'b0;
      exp_busy  = 1'b0;
      exp_count = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      bit          pushed;
      logic [31:0] d;
      int          x0, p0, nsz;

      rst_ni           = 1'b1;
      bus.src_valid_i  = 1'b0;
      bus.src_data_i   = '0;
      bus.noc_credit_i = 1'b0;
      #2;
      do_reset();

      // Basic 5-flit packet with continuous credit
      src_q = '{32'h0000_0102, 32'd3, 32'hA, 32'hB, 32'hC};
      run_src(100, 100, 100);
      check_val("basic_count", 64'(sent_count_o), 64'd1);

      // Zero-length packet
      src_q = '{32'h0000_0011, 32'd0};
      run_src(100, 100, 100);
      check_val("zero_len_count", 64'(sent_count_o), 64'd2);
      check_val("zero_len_idle", 64'(busy_o), 64'd0);

      // Fill with credit low, one-cycle credit, order across pointer wrap
      for (int i = 0; i < BUF; i++) begin
         d = (i == 0) ? 32'h21 : (i == 1) ? 32'd6 : 32'h100 + 32'(i);
         step(1'b1, d, 1'b0, pushed);
      end
      step(1'b1, 32'h22, 1'b0, pushed);   // refused: full
      check_val("full_refused", 64'(pushed), 64'd0);
      step(1'b1, 32'h22, 1'b1, pushed);   // one pop, still no write
      step(1'b0, 32'h0, 1'b0, pushed);    // ready back high (checked here)
      check_val("ready_after_pop", 64'(bus.src_ready_o), 64'd1);
      step(1'b1, 32'h22, 1'b0, pushed);
      step(1'b1, 32'h0, 1'b0, pushed);
      run_src(100, 100, 100);

      // Payload 20 with random credit
      x0 = n_xfer; p0 = n_pkts;
      src_q = '{32'h5, 32'd20};
      for (int i = 0; i < 20; i++) src_q.push_back($urandom);
      run_src(100, 50, 1000);
      check_val("p20_xfers", 64'(n_xfer - x0), 64'd22);
      check_val("p20_pkts", 64'(n_pkts - p0), 64'd1);

      // Reset in the middle of a packet
      src_q = '{32'h7, 32'd5, 32'h51, 32'h52};
      run_src(100, 100, 100);
      check_val("mid_busy", 64'(busy_o), 64'd1);
      do_reset();
      src_q = '{32'h1, 32'd1, 32'hD};
      run_src(100, 100, 100);
      check_val("post_rst_count", 64'(sent_count_o), 64'd1);

      // Random packets, random valid and credit
      for (int p = 0; p < 25; p++) begin
         nsz = $urandom_range(6);
         src_q.push_back($urandom);
         src_q.push_back(32'(nsz));
         for (int i = 0; i < nsz; i++) src_q.push_back($urandom);
      end
      p0 = n_pkts;
      run_src(70, 60, 5000);
      check_val("rand_pkts", 64'(n_pkts - p0), 64'd25);

      // Counter wrap
      step(1'b0, 32'h0, 1'b0, pushed);
      force dut.sent_count_reg = 32'hFFFF_FFFF;
      exp_count = 32'hFFFF_FFFF;
      step(1'b0, 32'h0, 1'b0, pushed);
      release dut.sent_count_reg;
      step(1'b0, 32'h0, 1'b0, pushed);
      src_q = '{32'h1, 32'd0};
      run_src(100, 100, 100);
      check_val("wrap_count", 64'(sent_count_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
